traffic_light_sequencer: RTL
============================

# traffic_light_sequencer

Hardware phase sequencer for the four-approach intersection. It drives the four 3-bit traffic-light lamp buses (`tl_0`..`tl_3`), a seconds countdown for the hex display drivers and a heartbeat LED. It replaces software sequencing on the soft processor. Approaches 0/2 form the north-south (NS) pair and 1/3 the east-west (EW) pair, with vehicle-request latching, green rest and a maintenance flash mode.

## Interface
- `TICK_DIV`, 50000000: clock cycles per 1 s tick; must be ≥ 2.
- `GREEN_S`, 20: minimum green duration in ticks; range 1..255.
- `YELLOW_S`, 3: yellow duration in ticks; range 1..255.
- `ALLRED_S`, 2: all-red clearance duration in ticks; range 1..255.
- `clk_clk`  in  1  system clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = normal cycling; 0 = flash mode.
- `ns_req`  in  1  NS vehicle sensor, level; latched internally.
- `ew_req`  in  1  EW vehicle sensor, level; latched internally.
- `tl_0`..`tl_3`  out  3 each  lamp drive {red, yellow, green}, bit2 = red, one-hot except in flash.
- `countdown`  out  8  remaining ticks in the current phase, binary, for the hex decoders.
- `phase`  out  3  current state encoding (see Operation).
- `led`  out  1  heartbeat; toggles on every tick.

## Operation
- Tick generator: counter 0..TICK_DIV-1; `tick` is internal, high for one cycle when counter = TICK_DIV-1. The counter runs in every state.
- States and `phase` codes:
  - 0 NS_GREEN
  - 1 NS_YELLOW
  - 2 ALLRED_A
  - 3 EW_GREEN
  - 4 EW_YELLOW
  - 5 ALLRED_B
  - 6 FLASH
- Lamp outputs per state:
  - NS_GREEN: `tl_0`/`tl_2` = 001, `tl_1`/`tl_3` = 100.
  - NS_YELLOW: NS = 010, EW = 100.
  - ALLRED_A/B: all 100.
  - EW_GREEN/EW_YELLOW: mirror of the NS states.
  - FLASH: all = {0, `flash_bit`, 0}.
- Phase entry loads `countdown` with the phase duration: GREEN_S, YELLOW_S or ALLRED_S.
- On each tick with `countdown` > 1: `countdown` decrements by 1.
- On a tick with `countdown` = 1, the state advances:
  - NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B→NS_GREEN.
  - Green rest: in NS_GREEN the advance occurs only if `ew_lat` = 1; otherwise the state holds with `countdown` = 1. EW_GREEN behaves the same using `ns_lat`.
- Request latches:
  - `ns_lat` is set in any cycle with `ns_req` = 1 and cleared in the cycle NS_GREEN is entered. Set wins over clear in the same cycle only when the state is not NS_GREEN.
  - `ew_lat` behaves symmetrically.
- Flash:
  - `enable` = 0 in any non-FLASH state moves to FLASH on the next clock edge, regardless of tick or countdown.
  - In FLASH, `countdown` = 0 and `flash_bit` toggles on each tick.
  - `enable` = 1 in FLASH moves to ALLRED_B with `countdown` = ALLRED_S; `flash_bit` clears.
- Widths: `countdown` is 8-bit unsigned and never wraps; its minimum is 1 in timed states. The tick counter is `$clog2(TICK_DIV)` bits.

## Timing
- Reset values (asynchronous): state ALLRED_B, `phase` = 5, all `tl_*` = 100, `countdown` = ALLRED_S, tick counter 0, `led` 0, `flash_bit` 0. Request latches are cleared.
- First tick occurs TICK_DIV cycles after the first rising edge following reset release.
- All outputs are registered. A state change, its lamp pattern and its new `countdown` appear together on the edge on which `tick` is sampled high, so there is no intermediate pattern.
- Each timed phase lasts exactly N ticks (N × TICK_DIV cycles), measured from entry; a green may extend beyond N by green rest.
- Reset asserted mid-phase returns to the reset values immediately, without waiting for a clock edge.
- If `enable` falls and a tick occurs in the same cycle, FLASH wins.
- Entry to FLASH is 1 cycle after `enable` is sampled low; exit is 1 cycle after `enable` is sampled high.

## Test plan
Parameters for all scenarios: TICK_DIV=4, GREEN_S=5, YELLOW_S=2, ALLRED_S=1.
1. Reset, `enable` = 1, `ns_req`/`ew_req` held 1 → NS_GREEN entered at cycle 4 with `countdown` = 5. NS_YELLOW follows at cycle 24, ALLRED_A at 32, EW_GREEN at 36. `led` toggles every 4 cycles.
2. `ew_req` = 0 throughout → NS_GREEN rests with `countdown` = 1 indefinitely. Pulse `ew_req` for 1 cycle → NS_YELLOW is entered on the next tick.
3. Drop `enable` mid-NS_GREEN → next cycle `phase` = 6, all `tl_*` alternate 000/010 every 4 cycles. Raise `enable` → ALLRED_B for 1 tick, then NS_GREEN.
4. Assert `reset_reset` mid-EW_YELLOW between clock edges → outputs show 100/`phase` 5/`countdown` 1 without waiting for a clock edge.
5. Lamp check across a full cycle → no approach ever shows more than one lamp bit outside FLASH, and NS and EW are never non-red simultaneously.
6. Pulse `ns_req` during NS_GREEN entry cycle → latch not set; pulse one cycle later → latch set, so EW_GREEN does not rest.

Source files
------------

// File: rtl/traffic_light_sequencer_if.sv
// traffic_light_sequencer_if: intersection control bundle.
// master drives enable/ns_req/ew_req and observes the lamp, countdown,
// phase and heartbeat outputs; slave (the sequencer) does the reverse.
interface traffic_light_sequencer_if;
    logic       enable;
    logic       ns_req;
    logic       ew_req;
    logic [2:0] tl_0;
    logic [2:0] tl_1;
    logic [2:0] tl_2;
    logic [2:0] tl_3;
    logic [7:0] countdown;
    logic [2:0] phase;
    logic       led;
    modport master (
        output enable, ns_req, ew_req,
        input  tl_0, tl_1, tl_2, tl_3, countdown, phase, led
    );
    modport slave (
        input  enable, ns_req, ew_req,
        output tl_0, tl_1, tl_2, tl_3, countdown, phase, led
    );
endinterface

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: four-approach NS/EW phase sequencer with request latching,
// green rest and maintenance flash.
// Ports: clk_clk (clock), reset_reset (async active-high reset),
// bus.enable (1 = cycle, 0 = flash), bus.ns_req/ew_req (level sensors),
// bus.tl_0..tl_3 ({red,yellow,green}, 0/2 = NS, 1/3 = EW), bus.countdown
// (ticks left in phase), bus.phase (state code), bus.led (heartbeat).
module traffic_light_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_S  = 20,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 2
) (
    input logic                        clk_clk,
    input logic                        reset_reset,
    traffic_light_sequencer_if.slave   bus
);
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        FLASH     = 3'd6
    } state_t;
    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    cd, nxt_cd;
    logic          fb, nxt_fb;
    logic          entry;
    logic          ns_lat, ew_lat;
    logic          hb;
    logic [2:0]    ns_lamp, ew_lamp;
    logic          tick, rest;
    function automatic logic [7:0] dur(state_t s);
        return (s == NS_GREEN || s == EW_GREEN) ? 8'(GREEN_S) :
               (s == NS_YELLOW || s == EW_YELLOW) ? 8'(YELLOW_S) : 8'(ALLRED_S);
    endfunction
    assign tick = cnt == CW'(TICK_DIV - 1);
    // a green with no waiting cross traffic holds at countdown 1
    assign rest = (state == NS_GREEN && !ew_lat) || (state == EW_GREEN && !ns_lat);
    always_comb begin
        nxt    = state;
        nxt_cd = cd;
        nxt_fb = fb;
        if (!bus.enable) begin
            nxt    = FLASH;
            nxt_cd = 8'd0;
            nxt_fb = (state == FLASH && tick) ? ~fb : fb;
        end else if (state == FLASH) begin
            nxt    = ALLRED_B;
            nxt_cd = 8'(ALLRED_S);
            nxt_fb = 1'b0;
        end else if (tick && cd > 8'd1) begin
            nxt_cd = cd - 8'd1;
        end else if (tick && !rest) begin
            nxt    = (state == ALLRED_B) ? NS_GREEN : state_t'(state + 3'd1);
            nxt_cd = dur(nxt);
        end
    end
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state   <= ALLRED_B;
            cd      <= 8'(ALLRED_S);
            cnt     <= '0;
            hb      <= 1'b0;
            fb      <= 1'b0;
            entry   <= 1'b0;
            ns_lat  <= 1'b0;
            ew_lat  <= 1'b0;
            ns_lamp <= 3'b100;
            ew_lamp <= 3'b100;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            hb      <= hb ^ tick;
            state   <= nxt;
            cd      <= nxt_cd;
            fb      <= nxt_fb;
            entry   <= nxt != state;
            // lamps decode the next state so they move on the same edge as phase
            ns_lamp <= nxt == NS_GREEN ? 3'b001 : nxt == NS_YELLOW ? 3'b010 :
                       nxt == FLASH ? {1'b0, nxt_fb, 1'b0} : 3'b100;
            ew_lamp <= nxt == EW_GREEN ? 3'b001 : nxt == EW_YELLOW ? 3'b010 :
                       nxt == FLASH ? {1'b0, nxt_fb, 1'b0} : 3'b100;
            // the first cycle spent in a green clears its own request, beating a new one
            ns_lat  <= !(state == NS_GREEN && entry) && (ns_lat || bus.ns_req);
            ew_lat  <= !(state == EW_GREEN && entry) && (ew_lat || bus.ew_req);
        end
    end
    assign bus.tl_0      = ns_lamp;
    assign bus.tl_2      = ns_lamp;
    assign bus.tl_1      = ew_lamp;
    assign bus.tl_3      = ew_lamp;
    assign bus.countdown = cd;
    assign bus.phase     = state;
    assign bus.led       = hb;
endmodule
